bfp_exponent_ctrl: RTL

Block-floating-point scheduler for the FFT datapath.
- Observes every butterfly output of the current stage and tracks the largest significant bit width.
- At each stage boundary, programs the bit-width operand consumed by the BFP shifter for the next stage.
- Accumulates the frame's block exponent and hands it downstream with a valid/ready handshake once the last stage completes.

---
 rtl/bfp_exponent_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/bfp_exponent_ctrl.sv
// Block-floating-point exponent scheduler for the FFT datapath.
// The block watches each butterfly output in a stage and tracks the widest sample.
// At every stage boundary it programs the width code for the shifter and adds the
// implied left shift to the frame's block exponent. After the last stage it offers
// the exponent downstream.
// Optional macro BFP_HEADROOM_FLAG_EN adds the sticky headroom_lost output. That flag
// is set when the width clamp engaged and no guard headroom was reserved.
// Handshake: a sample transfers on a clock edge where obs_valid && obs_ready.
// The exponent transfers on a clock edge where exp_valid && exp_ready. exp_valid and
// block_exponent hold steady until that transfer.
module bfp_exponent_ctrl #(
    parameter int FFT_DW            = 16,
    parameter int FFT_MAX_BIT_WIDTH = 5,
    parameter int FFT_STAGES        = 10,
    parameter int GUARD_BITS        = 1,
    parameter int EXP_W             = 6
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              frame_start,
    input  logic                              obs_valid,
    input  logic [FFT_DW-1:0]                 obs_data,
    input  logic                              stage_done,
    output logic                              obs_ready,
    output logic [FFT_MAX_BIT_WIDTH-1:0]      current_variable_bit_width,
    output logic                              width_update,
    output logic [$clog2(FFT_STAGES+1)-1:0]   stage_idx,
    output logic [EXP_W-1:0]                  block_exponent,
    output logic                              exp_valid,
    input  logic                              exp_ready,
`ifdef BFP_HEADROOM_FLAG_EN
    output logic                              headroom_lost,
`endif
    output logic [1:0]                        dbg_state
);

    localparam int MW_W   = $clog2(FFT_DW + 1);
    localparam int CW     = MW_W + 1;
    localparam int SIDX_W = $clog2(FFT_STAGES + 1);
    localparam logic [FFT_DW-1:0] MOST_NEG = {1'b1, {(FFT_DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, APPLY = 2'd2, DONE = 2'd3} state_t;

    state_t              state, state_nxt;
    logic [MW_W-1:0]     max_w;
    logic [MW_W-1:0]     samp_w;
    logic [FFT_DW-1:0]   mag;
    logic                restart;
    logic                accept;
    logic                clamp;
    logic [CW-1:0]       grown;
    logic [CW-1:0]       new_w;
    logic [CW-1:0]       shift_amt;
    logic [EXP_W:0]      exp_sum;
    logic [EXP_W-1:0]    exp_sat;
    logic [SIDX_W-1:0]   idx_nxt;

    assign obs_ready = (state == RUN);
    assign exp_valid = (state == DONE);
    assign dbg_state = state;

    // A new frame aborts any frame in progress. The only exception is DONE, where the
    // pending exponent must first be handed off.
    assign restart = frame_start && (state != DONE);
    assign accept  = obs_valid && obs_ready && !frame_start;

    // Significant width of the incoming sample. A negative value is measured on its
    // complement. The most-negative value is the only one that needs every bit.
    always_comb begin
        mag    = obs_data[FFT_DW-1] ? ~obs_data : obs_data;
        samp_w = '0;
        if (obs_data == MOST_NEG) begin
            samp_w = MW_W'(FFT_DW);
        end else begin
            for (int i = 0; i < FFT_DW; i++) begin
                if (mag[i]) samp_w = MW_W'(i + 1);
            end
        end
    end

    // Stage result: grow by the guard bits, clamp to the shifter range, and derive the
    // left shift the shifter will apply at that width.
    always_comb begin
        grown     = CW'(max_w) + CW'(GUARD_BITS);
        clamp     = grown > CW'(FFT_DW - 1);
        new_w     = '0;
        shift_amt = '0;
        if (max_w != '0) begin
            new_w     = clamp ? CW'(FFT_DW - 1) : grown;
            shift_amt = CW'(FFT_DW - 1) - new_w;
        end
        exp_sum = (EXP_W+1)'(block_exponent) + (EXP_W+1)'(shift_amt);
        exp_sat = exp_sum[EXP_W] ? {EXP_W{1'b1}} : exp_sum[EXP_W-1:0];
        idx_nxt = stage_idx + SIDX_W'(1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic. frame_start takes priority over stage_done.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start) state_nxt = RUN;
            RUN:     if (frame_start) state_nxt = RUN;
                     else if (stage_done) state_nxt = APPLY;
            APPLY:   if (frame_start) state_nxt = RUN;
                     else if (idx_nxt == SIDX_W'(FFT_STAGES)) state_nxt = DONE;
                     else state_nxt = RUN;
            DONE:    if (exp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: track max width in RUN, commit the stage result in APPLY, and clear
    // everything on a frame restart.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_w                      <= '0;
            stage_idx                  <= '0;
            block_exponent             <= '0;
            current_variable_bit_width <= '0;
            width_update               <= 1'b0;
`ifdef BFP_HEADROOM_FLAG_EN
            headroom_lost              <= 1'b0;
`endif
        end else begin
            width_update <= 1'b0;
            if (restart) begin
                max_w                      <= '0;
                stage_idx                  <= '0;
                block_exponent             <= '0;
                current_variable_bit_width <= '0;
`ifdef BFP_HEADROOM_FLAG_EN
                headroom_lost              <= 1'b0;
`endif
            end else if (state == RUN) begin
                if (accept && (samp_w > max_w)) max_w <= samp_w;
            end else if (state == APPLY) begin
                current_variable_bit_width <= FFT_MAX_BIT_WIDTH'(new_w);
                width_update               <= 1'b1;
                block_exponent             <= exp_sat;
                stage_idx                  <= idx_nxt;
                max_w                      <= '0;
`ifdef BFP_HEADROOM_FLAG_EN
                if (clamp) headroom_lost <= 1'b1;
`endif
            end
        end
    end

endmodule
